data_memory_lsu: RTL

Byte-addressed, parametrised data memory with integrated load/store handling. It supports byte, half-word and word accesses, and generates byte enables internally. Loads are sign- or zero-extended, and the read latency is configurable. It sits behind the core's MEM stage on a valid/ready request port with a single-pulse response, and replaces the plain word-indexed data memory.

---
 rtl/data_memory_lsu_if.sv | 29 ++
 rtl/data_memory_lsu.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/data_memory_lsu_if.sv
// Request/response bundle between the MEM stage and the data memory LSU.
interface data_memory_lsu_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [XLEN-1:0] req_addr;
  logic [1:0]      req_size;
  logic            req_unsigned;
  logic [XLEN-1:0] req_wdata;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_fault;

  modport master (
    output req_valid, req_we, req_addr,
    output req_size, req_unsigned, req_wdata,
    input  req_ready, rsp_valid,
    input  rsp_rdata, rsp_fault
  );

  modport slave (
    input  req_valid, req_we, req_addr,
    input  req_size, req_unsigned, req_wdata,
    output req_ready, rsp_valid,
    output rsp_rdata, rsp_fault
  );
endinterface

// File: rtl/data_memory_lsu.sv
// Byte-addressed data memory with load/store lane handling.
// Define DMEM_MISALIGN_TRAP_EN to fault misaligned half/word accesses.
module data_memory_lsu #(
  parameter int DEPTH  = 1024,
  parameter int XLEN   = 32,
  parameter int RD_LAT = 1
) (
  input logic               clk,
  input logic               reset,
  data_memory_lsu_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] LAT_M1 = 2'(RD_LAT - 1);

  if (XLEN != 32) begin : g_xlen_chk
    $error("data_memory_lsu: XLEN must be 32");
  end
  if (DEPTH < 4 || (1 << AW) != DEPTH) begin : g_depth_chk
    $error("data_memory_lsu: DEPTH must be a power of two >= 4");
  end
  if (RD_LAT < 1 || RD_LAT > 4) begin : g_lat_chk
    $error("data_memory_lsu: RD_LAT must be 1..4");
  end

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t          state_q;
  logic [1:0]      cnt_q;
  logic            ready_q;
  logic            rsp_valid_q;
  logic            rsp_fault_q;
  logic [XLEN-1:0] rsp_rdata_q;
  logic [XLEN-1:0] ld_q;
  logic [XLEN-1:0] mem_q [DEPTH];

  logic            hw, wo, mis, oor, bad, fault, acc;
  logic [1:0]      lane;
  logic [AW-1:0]   idx;
  logic [3:0]      be;
  logic [XLEN-1:0] wd, word, ld;
  logic [15:0]     sh;

  assign hw = bus.req_size == 2'b01;
  assign wo = bus.req_size == 2'b10;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign mis  = (hw & bus.req_addr[0]) | (wo & |bus.req_addr[1:0]);
  assign lane = bus.req_addr[1:0];
`else
  // Misaligned accesses silently snap to the aligned location.
  assign mis  = 1'b0;
  assign lane = wo ? 2'b00 :
                hw ? {bus.req_addr[1], 1'b0} :
                bus.req_addr[1:0];
`endif

  assign idx   = bus.req_addr[AW+1:2];
  assign oor   = |bus.req_addr[XLEN-1:AW+2];
  assign word  = mem_q[idx];
  assign sh    = 16'(word >> {lane, 3'b000});
  assign fault = bad | oor | mis;
  assign acc   = bus.req_valid & ready_q;

  always_comb begin
    bad = 1'b0;
    be  = 4'b0000;
    wd  = bus.req_wdata;
    ld  = word;
    unique case (1'b1)
      bus.req_size == 2'b00: begin
        be = 4'b0001 << lane;
        wd = {4{bus.req_wdata[7:0]}};
        ld = bus.req_unsigned ? {24'b0, sh[7:0]}
                              : {{24{sh[7]}}, sh[7:0]};
      end
      hw: begin
        be = 4'b0011 << lane;
        wd = {2{bus.req_wdata[15:0]}};
        ld = bus.req_unsigned ? {16'b0, sh}
                              : {{16{sh[15]}}, sh};
      end
      wo: begin
        be = 4'b1111;
      end
      default: bad = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (acc && bus.req_we && !fault) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem_q[idx][8*b +: 8] <= wd[8*b +: 8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
      rsp_rdata_q <= '0;
      ld_q        <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
      rsp_rdata_q <= '0;
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (acc) begin
            ready_q <= 1'b0;
            ld_q    <= ld;
            cnt_q   <= 2'd1;
            if (bus.req_we || fault || RD_LAT == 1) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_fault_q <= fault;
              rsp_rdata_q <= (bus.req_we || fault) ? '0 : ld;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt_q == LAT_M1) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= ld_q;
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        RESP: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_fault = rsp_fault_q;
  assign bus.rsp_rdata = rsp_rdata_q;
endmodule
